bcd2_seg_scan: RTL and testbench

BCD2_SEG_SCAN -- requirements
Module: bcd2_seg_scan

---
 rtl/bcd2_seg_scan.sv | 112 +++++++++++
 tb/tb_bcd2_seg_scan.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd2_seg_scan.sv
// rtl/bcd2_seg_scan.sv - two-digit BCD to 7-segment multiplexed display scanner
// Outputs decode from registered state only; ld reloads the digits and restarts the scan.
module bcd2_seg_scan #(
  parameter int DIV      = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       ld,
  input  logic [3:0] d,
  input  logic [3:0] u,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHOW_U = 2'd1;
  localparam logic [1:0] S_SHOW_D = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    dr_q, dr_d;
  logic [3:0]    ur_q, ur_d;

  function automatic logic [6:0] enc(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // A load always wins, including over the phase wrap, so every load starts a full units phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dr_d    = dr_q;
    ur_d    = ur_q;
    if (ld) begin
      dr_d    = d;
      ur_d    = u;
      cnt_d   = '0;
      state_d = S_SHOW_U;
    end else begin
      case (state_q)
        S_SHOW_U, S_SHOW_D: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = (state_q == S_SHOW_U) ? S_SHOW_D : S_SHOW_U;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dr_q    <= 4'd0;
      ur_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dr_q    <= dr_d;
      ur_q    <= ur_d;
    end
  end

  // Blanked leading zero keeps its enable asserted so the scan rhythm never changes.
  always_comb begin
    seg = 7'h00;
    an  = 2'b11;
    err = 1'b0;
    case (state_q)
      S_SHOW_U: begin
        an  = 2'b10;
        seg = enc(ur_q);
        err = (dr_q > 4'd9) | (ur_q > 4'd9);
      end
      S_SHOW_D: begin
        an  = 2'b01;
        seg = (BLANK_LZ && (dr_q == 4'd0)) ? 7'h00 : enc(dr_q);
        err = (dr_q > 4'd9) | (ur_q > 4'd9);
      end
      default: begin
        seg = 7'h00;
        an  = 2'b11;
        err = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd2_seg_scan.sv
// tb/tb_bcd2_seg_scan.sv - directed bench for bcd2_seg_scan
// Two instances (leading-zero blanking on/off) checked every cycle against a cycle-count model.
module tb_bcd2_seg_scan;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] d = 4'd0;
  logic [3:0] u = 4'd0;
  logic [6:0] seg0, seg1;
  logic [1:0] an0, an1;
  logic       err0, err1;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd2_seg_scan #(.DIV(DIV), .BLANK_LZ(1'b1)) dut0 (
    .clk(clk), .rst_b(rst_b), .ld(ld), .d(d), .u(u),
    .seg(seg0), .an(an0), .err(err0)
  );

  bcd2_seg_scan #(.DIV(DIV), .BLANK_LZ(1'b0)) dut1 (
    .clk(clk), .rst_b(rst_b), .ld(ld), .d(d), .u(u),
    .seg(seg1), .an(an1), .err(err1)
  );

  logic [6:0] enc_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Model: cycles elapsed since the last load decide which digit is lit.
  bit         m_loaded;
  int         m_k;
  logic [3:0] m_d, m_u;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_loaded <= 1'b0;
      m_k      <= 0;
      m_d      <= 4'd0;
      m_u      <= 4'd0;
    end else if (ld) begin
      m_loaded <= 1'b1;
      m_k      <= 0;
      m_d      <= d;
      m_u      <= u;
    end else if (m_loaded) begin
      m_k <= m_k + 1;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_out(input bit blz, output logic [6:0] s, output logic [1:0] a,
                           output logic e);
    if (!m_loaded) begin
      s = 7'h00; a = 2'b11; e = 1'b0;
    end else begin
      e = (m_d > 9) || (m_u > 9);
      if (((m_k / DIV) % 2) == 0) begin
        a = 2'b10; s = enc_tab[m_u];
      end else begin
        a = 2'b01; s = (blz && m_d == 4'd0) ? 7'h00 : enc_tab[m_d];
      end
    end
  endtask

  always @(negedge clk) begin
    logic [6:0] es;
    logic [1:0] ea;
    logic       ee;
    if (chk_en) begin
      model_out(1'b1, es, ea, ee);
      chk("m0_seg", 16'(seg0), 16'(es));
      chk("m0_an",  16'(an0),  16'(ea));
      chk("m0_err", 16'(err0), 16'(ee));
      model_out(1'b0, es, ea, ee);
      chk("m1_seg", 16'(seg1), 16'(es));
      chk("m1_an",  16'(an1),  16'(ea));
      chk("m1_err", 16'(err1), 16'(ee));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] dd, input logic [3:0] uu);
    d = dd; u = uu; ld = 1'b1;
    cyc();
    ld = 1'b0;
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst_an", 16'(an0), 16'h3);
    chk("rst_seg", 16'(seg0), 16'h0);
    chk("rst_err", 16'(err0), 16'h0);
    rst_b = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_an", 16'(an0), 16'h3);
      chk("idle_seg", 16'(seg0), 16'h0);
    end

    // 45: units 5 for cycles 1-4, tens 4 for 5-8, units again at 9
    load(4'd4, 4'd5);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) cyc();
      if (c <= 4 || (c >= 9 && c <= 12)) begin
        chk("s45_an_u", 16'(an0), 16'h2);
        chk("s45_seg_u", 16'(seg0), 16'h6D);
      end else begin
        chk("s45_an_d", 16'(an0), 16'h1);
        chk("s45_seg_d", 16'(seg0), 16'h66);
      end
    end

    // ld on the last tens cycle: reload wins over the wrap
    load(4'd1, 4'd0);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) cyc();
      if (c <= 4) begin
        chk("wrap_an_u", 16'(an0), 16'h2);
        chk("wrap_seg_u", 16'(seg0), 16'h3F);
      end else begin
        chk("wrap_an_d", 16'(an0), 16'h1);
        chk("wrap_seg_d", 16'(seg0), 16'h06);
      end
    end

    load(4'd0, 4'd5);
    repeat (4) cyc();
    chk("lz_an", 16'(an0), 16'h1);
    chk("lz_seg_blank", 16'(seg0), 16'h00);
    chk("lz_seg_noblank", 16'(seg1), 16'h3F);
    chk("lz_err", 16'(err0), 16'h0);

    load(4'd0, 4'd12);
    chk("bad_u_err", 16'(err0), 16'h1);
    chk("bad_u_seg", 16'(seg0), 16'h40);
    chk("bad_u_an", 16'(an0), 16'h2);

    load(4'd11, 4'd3);
    repeat (4) cyc();
    chk("bad_d_seg", 16'(seg0), 16'h40);
    chk("bad_d_err", 16'(err0), 16'h1);

    // ld held high: continuous reload stays on the units phase
    d = 4'd2; u = 4'd7; ld = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk("hold_an", 16'(an0), 16'h2);
      chk("hold_seg", 16'(seg0), 16'(enc_tab[u]));
      u = 4'(c);
    end
    ld = 1'b0;
    repeat (4) cyc();
    chk("hold_after_an", 16'(an0), 16'h1);

    // asynchronous reset mid-units phase
    load(4'd7, 4'd8);
    cyc();
    #2 rst_b = 1'b0;
    #1;
    chk("arst_an", 16'(an0), 16'h3);
    chk("arst_seg", 16'(seg0), 16'h0);
    chk("arst_err", 16'(err0), 16'h0);
    cyc();
    #2 rst_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("post_rst_an", 16'(an0), 16'h3);
    end

    // ld at the first edge after release is accepted
    #2 rst_b = 1'b0;
    d = 4'd2; u = 4'd3; ld = 1'b1;
    #1 rst_b = 1'b1;
    cyc();
    ld = 1'b0;
    chk("rel_ld_an", 16'(an0), 16'h2);
    chk("rel_ld_seg", 16'(seg0), 16'h4F);
    repeat (4) cyc();
    chk("rel_ld_seg_d", 16'(seg0), 16'h5B);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
